// File: rtl/m31_pkg.sv
// Shared M31 field types and constants for the Monolith datapath.
// Provides the element type, the prime P = 2^31-1, a full-vector type,
// and the stream-port FSM state encoding.
package m31_pkg;

  localparam int M31_VEC_LEN = 16;

  typedef logic [30:0] m31_t;

  localparam m31_t M31_P = 31'h7FFFFFFF;

  typedef m31_t m31_vec_t [0:M31_VEC_LEN-1];

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } port_state_t;

endpackage

// File: rtl/m31_canon.sv
// Canonicalizes one M31 word: the non-canonical encoding P maps to 0.
// Latency: combinational, zero cycles. Backpressure: none (pure function).
// Ports: word (raw element in), canon (canonical element out).
module m31_canon
  import m31_pkg::*;
(
  input  m31_t word,
  output m31_t canon
);

  assign canon = (word == M31_P) ? '0 : word;

endmodule

// File: rtl/circ_mvm_stream_port.sv
// Stream front/back end for the circulant MVM: deserialize + canonicalize a
// vector, strobe it to the MVM, capture the result, serialize it back out.
// Latency: last accept t -> mvm_in_valid t+1 -> capture >= t+1+MVM_LATENCY ->
// first m_valid the next cycle. Backpressure: s_ready low outside LOAD;
// m_ready low holds m_data/m_last/out_idx.
// Ports: s_* input stream, mvm_vec/mvm_in_valid to MVM, mvm_result/
// mvm_result_valid from MVM, m_* output stream, frame_err malformed-frame pulse.
module circ_mvm_stream_port
  import m31_pkg::*;
#(
  parameter int WORD_WIDTH  = 31,
  parameter int MTX_SIZE    = 16,
  parameter int MVM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic [WORD_WIDTH-1:0] mvm_vec [0:MTX_SIZE-1],
  output logic                  mvm_in_valid,
  input  logic [WORD_WIDTH-1:0] mvm_result [0:MTX_SIZE-1],
  input  logic                  mvm_result_valid,
  output logic [WORD_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  frame_err
);

  localparam int IW = (MTX_SIZE > 1) ? $clog2(MTX_SIZE) : 1;
  localparam int LW = (MVM_LATENCY > 0) ? $clog2(MVM_LATENCY + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(MTX_SIZE - 1);
  localparam logic [LW-1:0] LAT_MAX  = LW'(MVM_LATENCY);

  port_state_t           state;
  logic [IW-1:0]         in_idx;
  logic [IW-1:0]         out_idx;
  logic [LW-1:0]         lat_cnt;
  logic [WORD_WIDTH-1:0] ibuf [0:MTX_SIZE-1];
  logic [WORD_WIDTH-1:0] obuf [0:MTX_SIZE-1];
  m31_t                  s_canon;

  m31_canon u_canon (
    .word  (m31_t'(s_data)),
    .canon (s_canon)
  );

  // The input buffer feeds the MVM continuously; mvm_in_valid qualifies it.
  assign mvm_vec = ibuf;

  // Only the output-side data path follows out_idx combinationally.
  assign m_data = obuf[out_idx];
  assign m_last = m_valid && (out_idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_LOAD;
      in_idx       <= '0;
      out_idx      <= '0;
      lat_cnt      <= '0;
      s_ready      <= 1'b0;
      mvm_in_valid <= 1'b0;
      m_valid      <= 1'b0;
      frame_err    <= 1'b0;
      for (int i = 0; i < MTX_SIZE; i++) begin
        ibuf[i] <= '0;
        obuf[i] <= '0;
      end
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_LOAD: begin
          // s_ready is a registered copy of "in LOAD", so it rises one
          // cycle after reset release rather than during reset.
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            ibuf[in_idx] <= WORD_WIDTH'(s_canon);
            if (in_idx == LAST_IDX || s_last) begin
              // Short frame: stale words from the previous frame must not
              // reach the MVM, so everything past the last accepted word
              // is cleared.
              for (int i = 0; i < MTX_SIZE; i++) begin
                if (i > int'(in_idx)) begin
                  ibuf[i] <= '0;
                end
              end
              // Malformed if s_last came early or never came at all.
              frame_err    <= (in_idx == LAST_IDX) ? !s_last : 1'b1;
              s_ready      <= 1'b0;
              mvm_in_valid <= 1'b1;
              lat_cnt      <= '0;
              state        <= ST_ISSUE;
            end else begin
              in_idx <= in_idx + 1'b1;
            end
          end
        end

        ST_ISSUE: begin
          // Saturating, so reaching LAT_MAX means ">= MVM_LATENCY".
          if (lat_cnt != LAT_MAX) begin
            lat_cnt <= lat_cnt + 1'b1;
          end
          if (lat_cnt == LAT_MAX && mvm_result_valid) begin
            for (int i = 0; i < MTX_SIZE; i++) begin
              obuf[i] <= mvm_result[i];
            end
            out_idx      <= '0;
            mvm_in_valid <= 1'b0;
            m_valid      <= 1'b1;
            state        <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (m_ready) begin
            if (out_idx == LAST_IDX) begin
              m_valid <= 1'b0;
              out_idx <= '0;
              in_idx  <= '0;
              s_ready <= 1'b1;
              state   <= ST_LOAD;
            end else begin
              out_idx <= out_idx + 1'b1;
            end
          end
        end

        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

endmodule
